tff_mod_counter: RTL

Parametrised modulo-N up/down counter built on toggle-flip-flop next-state logic; the successor to the single-bit positive-edge T flip-flop. Each bit of the count register toggles on a rising `Clk` edge when its computed toggle term is 1, which generalises the one-bit toggle to WIDTH bits. Adds a programmable modulus, a direction select, parallel load, and terminal-count and wrap flags. Used as the lab's standard event/divider counter.

---
 rtl/tff_mod_counter.sv | 94 +++++++++
 1 files changed

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter with T-flip-flop style next-state update, parallel load,
// terminal-count and wrap flags. Optional synchronous clear: define TFF_CNT_SYNCH_CLEAR_EN.
module tff_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
`ifdef TFF_CNT_SYNCH_CLEAR_EN
  input  logic             synch_clr,
`endif
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // One extra bit so MODULUS == 2**WIDTH is representable for the load range check.
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH-1:0] w_qn;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap_n;
  logic             w_load_err_n;
  logic             w_load_ok;
  logic             w_clr;

  assign w_load_ok = ({1'b0, load_val} < LP_MOD);

`ifdef TFF_CNT_SYNCH_CLEAR_EN
  assign w_clr = synch_clr;
`else
  assign w_clr = 1'b0;
`endif

  always_comb begin
    w_qn         = r_q;
    w_wrap_n     = 1'b0;
    w_load_err_n = 1'b0;
    if (w_clr) begin
      w_qn = '0;
    end else if (load) begin
      if (w_load_ok) w_qn = load_val;
      else           w_load_err_n = 1'b1;
    end else if (en) begin
      if (up_dn) begin
        if (r_q == LP_MAX) begin
          w_qn     = '0;
          w_wrap_n = 1'b1;
        end else begin
          w_qn = r_q + LP_ONE;
        end
      end else begin
        if (r_q == '0) begin
          w_qn     = LP_MAX;
          w_wrap_n = 1'b1;
        end else begin
          w_qn = r_q - LP_ONE;
        end
      end
    end
  end

  // Each bit toggles exactly where the target state differs from the current one.
  assign w_t = r_q ^ w_qn;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q        <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= r_q ^ w_t;
      r_wrap     <= w_wrap_n;
      r_load_err <= w_load_err_n;
    end
  end

  assign Q        = r_q;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;
  assign tc       = up_dn ? (r_q == LP_MAX) : (r_q == '0);

endmodule
